// File: rtl/register_bank_8x4_if.sv
// Write/clear handshake and parallel read bus for the 8x4 register bank.
// Master drives requests; slave returns acks, status and register contents.
interface register_bank_8x4_if #(
  parameter int WIDTH = 4
);
  logic             WE;
  logic [2:0]       WA;
  logic [WIDTH-1:0] WDin;
  logic             CLR;
  logic             WAck;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] Dout0;
  logic [WIDTH-1:0] Dout1;
  logic [WIDTH-1:0] Dout2;
  logic [WIDTH-1:0] Dout3;
  logic [WIDTH-1:0] Dout4;
  logic [WIDTH-1:0] Dout5;
  logic [WIDTH-1:0] Dout6;
  logic [WIDTH-1:0] Dout7;

  modport master (
    output WE,
    output WA,
    output WDin,
    output CLR,
    input  WAck,
    input  Busy,
    input  Done,
    input  Dout0,
    input  Dout1,
    input  Dout2,
    input  Dout3,
    input  Dout4,
    input  Dout5,
    input  Dout6,
    input  Dout7
  );

  modport slave (
    input  WE,
    input  WA,
    input  WDin,
    input  CLR,
    output WAck,
    output Busy,
    output Done,
    output Dout0,
    output Dout1,
    output Dout2,
    output Dout3,
    output Dout4,
    output Dout5,
    output Dout6,
    output Dout7
  );
endinterface

// File: rtl/register_bank_8x4.sv
// Eight-entry register bank feeding the 8:1 read mux: one write port with
// registered ack, plus a sequenced clear engine walking one entry per cycle.
module register_bank_8x4 #(
  parameter int               WIDTH     = 4,
  parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
  input  logic                clk,
  input  logic                rst,
  register_bank_8x4_if.slave  bus
);

  typedef enum logic {
    IDLE,
    CLEAR
  } state_e;

  state_e           state_q;
  state_e           state_d;
  logic [2:0]       idx_q;
  logic [2:0]       idx_d;
  logic             wack_q;
  logic             wack_d;
  logic             done_q;
  logic             done_d;
  logic [WIDTH-1:0] regs_q [8];
  logic [WIDTH-1:0] regs_d [8];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= 3'd0;
      wack_q  <= 1'b0;
      done_q  <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        regs_q[i] <= RESET_VAL;
      end
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      wack_q  <= wack_d;
      done_q  <= done_d;
      for (int i = 0; i < 8; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // CLR wins over WE in IDLE; both are ignored while clearing.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    wack_d  = 1'b0;
    done_d  = 1'b0;
    for (int i = 0; i < 8; i++) begin
      regs_d[i] = regs_q[i];
    end
    unique case (state_q)
      IDLE: begin
        if (bus.CLR) begin
          state_d = CLEAR;
          idx_d   = 3'd0;
        end else if (bus.WE) begin
          regs_d[bus.WA] = bus.WDin;
          wack_d         = 1'b1;
        end
      end
      CLEAR: begin
        regs_d[idx_q] = RESET_VAL;
        idx_d         = idx_q + 3'd1;
        if (idx_q == 3'd7) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = 3'd0;
      end
    endcase
  end

  assign bus.WAck  = wack_q;
  assign bus.Busy  = (state_q == CLEAR);
  assign bus.Done  = done_q;
  assign bus.Dout0 = regs_q[0];
  assign bus.Dout1 = regs_q[1];
  assign bus.Dout2 = regs_q[2];
  assign bus.Dout3 = regs_q[3];
  assign bus.Dout4 = regs_q[4];
  assign bus.Dout5 = regs_q[5];
  assign bus.Dout6 = regs_q[6];
  assign bus.Dout7 = regs_q[7];

endmodule
